// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler
// Per-scanline sprite evaluator: walks the attribute table one entry per
// cycle while the current line is displayed, collects up to MAX_PER_LINE
// sprites that cover the next line, and publishes them as a registered slot
// list on COMMIT.
// Optional feature macro: SPRITE_SCHED_DROP_CNT_EN adds a 16-bit saturating
// drop_count output counting sprites lost to slot overflow.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES  = 20,
  parameter int MAX_PER_LINE = 4,
  parameter int SPRITE_H     = 64,
  parameter int ROW_W        = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_SPRITES*24-1:0]       sprite_table,
  input  logic                            line_start,
  input  logic [9:0]                      next_line,
  output logic [MAX_PER_LINE-1:0]         slot_valid,
  output logic [MAX_PER_LINE*4-1:0]       slot_id,
  output logic [MAX_PER_LINE*10-1:0]      slot_x,
  output logic [MAX_PER_LINE*ROW_W-1:0]   slot_row,
  output logic                            list_done,
  output logic                            busy,
  output logic                            overflow
`ifdef SPRITE_SCHED_DROP_CNT_EN
  ,
  output logic [15:0]                     drop_count
`endif
);

  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int CNT_W = $clog2(MAX_PER_LINE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_COMMIT
  } state_t;

  state_t                          r_state;
  logic [9:0]                      r_line;
  logic [IDX_W-1:0]                r_idx;
  logic [CNT_W-1:0]                r_count;
  logic                            r_ovfW;
  logic [MAX_PER_LINE*4-1:0]       r_wId;
  logic [MAX_PER_LINE*10-1:0]      r_wX;
  logic [MAX_PER_LINE*ROW_W-1:0]   r_wRow;

  logic [23:0]                     w_entry;
  logic [3:0]                      w_id;
  logic [9:0]                      w_x;
  logic [9:0]                      w_y;
  logic [10:0]                     w_yEnd;
  logic [ROW_W-1:0]                w_row;
  logic                            w_hit;
  logic                            w_room;
  logic [MAX_PER_LINE-1:0]         w_validMask;

  // The bottom edge is formed in 11 bits so a sprite near line 1023 never
  // wraps around and appears at the top of the frame.
  assign w_entry = sprite_table[r_idx*24 +: 24];
  assign w_id    = w_entry[23:20];
  assign w_x     = w_entry[19:10];
  assign w_y     = w_entry[9:0];
  assign w_yEnd  = {1'b0, w_y} + 11'(SPRITE_H);
  assign w_row   = ROW_W'(r_line - w_y);
  assign w_hit   = (w_id != 4'd0) && (w_y <= r_line) && ({1'b0, r_line} < w_yEnd);
  assign w_room  = (r_count < CNT_W'(MAX_PER_LINE));

  // Valid bits for the committed list: the first r_count slots are filled.
  always_comb begin
    w_validMask = '0;
    for (int k = 0; k < MAX_PER_LINE; k++) begin
      w_validMask[k] = (CNT_W'(k) < r_count);
    end
  end

  // Scan/commit state machine; a line_start at the end overrides the normal
  // next state so a new scan can start from any state (restart in SCAN,
  // back-to-back after COMMIT).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_line     <= '0;
      r_idx      <= '0;
      r_count    <= '0;
      r_ovfW     <= 1'b0;
      r_wId      <= '0;
      r_wX       <= '0;
      r_wRow     <= '0;
      slot_valid <= '0;
      slot_id    <= '0;
      slot_x     <= '0;
      slot_row   <= '0;
      list_done  <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      list_done <= 1'b0;
      case (r_state)
        S_SCAN: begin
          if (w_hit && w_room) begin
            r_wId[r_count*4 +: 4]          <= w_id;
            r_wX[r_count*10 +: 10]         <= w_x;
            r_wRow[r_count*ROW_W +: ROW_W] <= w_row;
            r_count                        <= r_count + 1'b1;
          end else if (w_hit) begin
            r_ovfW <= 1'b1;
          end
          if (r_idx == IDX_W'(NUM_SPRITES - 1)) begin
            r_state <= S_COMMIT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_COMMIT: begin
          slot_valid <= w_validMask;
          slot_id    <= r_wId;
          slot_x     <= r_wX;
          slot_row   <= r_wRow;
          overflow   <= r_ovfW;
          list_done  <= 1'b1;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      if (line_start) begin
        r_line  <= next_line;
        r_idx   <= '0;
        r_count <= '0;
        r_ovfW  <= 1'b0;
        r_wId   <= '0;
        r_wX    <= '0;
        r_wRow  <= '0;
        busy    <= 1'b1;
        r_state <= S_SCAN;
      end
    end
  end

`ifdef SPRITE_SCHED_DROP_CNT_EN
  localparam int DROP_W = $clog2(NUM_SPRITES + 1);

  logic [DROP_W-1:0] r_lineDrops;
  logic [16:0]       w_dropSum;

  assign w_dropSum = {1'b0, drop_count} + 17'(r_lineDrops);

  // Drops are tallied per line and only folded into the total on COMMIT, so
  // an aborted scan never contributes; committing line 0 restarts the total.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lineDrops <= '0;
      drop_count  <= '0;
    end else begin
      if (r_state == S_SCAN && w_hit && !w_room) begin
        r_lineDrops <= r_lineDrops + 1'b1;
      end
      if (r_state == S_COMMIT) begin
        if (r_line == 10'd0) begin
          drop_count <= 16'(r_lineDrops);
        end else begin
          drop_count <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
        end
      end
      if (line_start) begin
        r_lineDrops <= '0;
      end
    end
  end
`endif

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sprite evaluation controller that sits between the Avalon-written sprite attribute table and the sprite controller / sprite ROM datapath.
- During each horizontal line it scans the whole attribute table and selects up to MAX_PER_LINE sprites that intersect the next line.
- It publishes a double-buffered slot list (id, x, row-within-sprite). The sprite datapath uses this list to share the sprite ROMs among only the visible sprites.

Parameters:
- NUM_SPRITES, 20, number of 24-bit attribute entries in sprite_table
- MAX_PER_LINE, 4, number of output slots per line
- SPRITE_H, 64, sprite height in lines (power of 2, ≤ 512)
- ROW_W, 6, width of slot row field, equal to log2(SPRITE_H)

Ports:
- clk  in  1  VGA pixel-domain clock
- reset  in  1  asynchronous, active-high reset
- sprite_table  in  NUM_SPRITES*24  flat attribute table; entry i = bits [24i+23:24i]; per entry: [23:20] sprite id (0 = disabled), [19:10] x, [9:0] y
- line_start  in  1  one-cycle pulse at start of horizontal blank
- next_line  in  10  line number to evaluate; sampled when line_start = 1
- slot_valid  out  MAX_PER_LINE  per-slot valid bits
- slot_id  out  MAX_PER_LINE*4  per-slot sprite id
- slot_x  out  MAX_PER_LINE*10  per-slot x position
- slot_row  out  MAX_PER_LINE*ROW_W  per-slot row = next_line − y
- list_done  out  1  one-cycle pulse when the output list updates
- busy  out  1  high while in SCAN or COMMIT
- overflow  out  1  set by COMMIT if the evaluated line had more than MAX_PER_LINE hits; held until the next COMMIT

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE.
  - All slot_* = 0, list_done = 0, busy = 0, overflow = 0.
  - Working list and index cleared.
- States: IDLE, SCAN, COMMIT.
- IDLE:
  - On line_start: latch next_line into L, clear the working list, set count = 0, ovf_w = 0, idx = 0, go to SCAN.
- SCAN (one entry per cycle, idx = 0 … NUM_SPRITES−1):
  - Hit when id ≠ 0 AND y ≤ L AND L < y + SPRITE_H.
  - The sum y + SPRITE_H is computed in 11 bits with no wrap, so sprites near line 1023 never wrap to line 0.
  - On a hit with count < MAX_PER_LINE: write slot[count] = {id, x, (L − y)[ROW_W−1:0]} and increment count.
  - On a hit with count = MAX_PER_LINE: set ovf_w; the sprite is dropped.
  - After idx = NUM_SPRITES−1 is evaluated, go to COMMIT.
- Priority: lower table index wins. Slot 0 holds the lowest-index hit, and slots are packed with no gaps.
- COMMIT (1 cycle):
  - Copy the working list to the output registers.
  - slot_valid[k] = (k < count); invalid slots have id/x/row = 0.
  - overflow = ovf_w, list_done = 1 for this cycle only.
  - Go to IDLE.
- Latency: line_start at cycle 0 → outputs and list_done valid at cycle NUM_SPRITES+2 (22 for defaults).
- Output registers hold their values between commits. They describe the line currently being displayed while the next line is being scanned.
- sprite_table is sampled live during SCAN. Writers update it during vertical blank; a mid-scan change affects only entries not yet visited.
- line_start while in SCAN: abort and restart from idx 0 with the new next_line. Outputs are not updated and there is no list_done for the aborted scan.
- line_start coincident with COMMIT: the commit completes, and the new scan starts on the next cycle.
- busy = 1 in SCAN and COMMIT.

Optional Feature:
- SPRITE_SCHED_DROP_CNT_EN defined:
  - Adds output port drop_count, 16 bits, a saturating count of sprites dropped for slot overflow.
  - Counts 1 per dropped hit, saturates at 0xFFFF.
  - Cleared by reset and by COMMIT of a line with L = 0; the count for line 0 restarts from that line's drops.
- Macro undefined: no port, no counter, no added logic.

Test Plan:
- Reset, then line_start with next_line = 100, all ids 0 → at cycle 22: list_done = 1, slot_valid = 4'b0000, overflow = 0.
- Entries 3 (id 5, x 200, y 80) and 7 (id 2, x 10, y 100), line_start with next_line = 100 → slot0 = {5, 200, row 20}, slot1 = {2, 10, row 0}, slot_valid = 4'b0011.
- Boundary: entry 0 id 1, y 36; next_line 99 → hit with row 63; next_line 100 → no hit. Entry with y 1000, next_line 8 → no hit (no wrap).
- Six entries (idx 0–5) all covering line 50 → slots hold idx 0–3 in order, overflow = 1. With SPRITE_SCHED_DROP_CNT_EN, drop_count = 2; a following line_start with next_line 0 and no hits → drop_count = 0.
- Second line_start at cycle 10 of a scan, next_line = 200 → no list_done at cycle 22; list_done at 22 cycles after the second pulse, with outputs for line 200.
- Assert reset during SCAN → all outputs 0 immediately (asynchronous) and state IDLE; the next line_start runs a full scan normally.
